uart_mmio_fifo: RTL and testbench

//  Memory-mapped UART front end between the core's MMIO bus and the uart block.

---
 rtl/uart_mmio_fifo_if.sv | 13 +
 rtl/uart_mmio_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_fifo_if.sv
// Valid/ready byte stream used between the MMIO UART front end and the uart block.
interface rv_if #(
  parameter int W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  // Producer side: offers data, waits for ready.
  modport TX (output valid, output data, input ready);
  // Consumer side: accepts data, drives ready.
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end. A TX FIFO decouples software writes from the
// serial transmitter, and an RX FIFO collects received bytes until software
// reads them. Register map (word index = mmio_addr[3:2]):
//   0 STATUS (RO), 1 TX_DATA (WO), 2 RX_DATA (RO, pops), 3 CLEAR (WO).
module uart_mmio_fifo #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_en,
  input  logic        mmio_we,
  input  logic [3:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  rv_if.TX            send_req,
  rv_if.RX            recv_rsp,
  output logic        rx_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0]   TX_CNT_ONE  = (TX_AW + 1)'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE  = (RX_AW + 1)'(1);
  localparam logic [TX_AW-1:0] TX_PTR_ONE  = TX_AW'(1);
  localparam logic [RX_AW-1:0] RX_PTR_ONE  = RX_AW'(1);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];

  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_AW:0]   tx_count_q,  tx_count_d;

  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_AW:0]   rx_count_q,  rx_count_d;

  logic             rx_overrun_q, rx_overrun_d;
  logic             tx_drop_q,    tx_drop_d;
  logic [31:0]      rdata_q,      rdata_d;

  // ---------------------------------------------------------------------------
  // Bus decode and FIFO events
  // ---------------------------------------------------------------------------
  logic [1:0]  reg_sel;
  logic        rd_req;
  logic        wr_req;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic        tx_push_req;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_push;
  logic        rx_pop;
  logic        clr_req;
  logic [7:0]  rx_head;
  logic [31:0] status_word;

  // Byte-lane bits and upper write data carry no meaning for this block.
  logic        unused_bits;
  assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:8]};

  assign reg_sel  = mmio_addr[3:2];
  assign rd_req   = mmio_en & ~mmio_we;
  assign wr_req   = mmio_en &  mmio_we;

  assign tx_full  = (tx_count_q == TX_FULL_CNT);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_FULL_CNT);
  assign rx_empty = (rx_count_q == '0);

  // Full flags are taken from the registered counts, so a same-cycle pop never
  // makes room for a push arriving in that cycle.
  assign tx_push_req = wr_req && (reg_sel == REG_TXDATA);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && send_req.ready;
  assign rx_push     = recv_rsp.valid && !rx_full;
  assign rx_pop      = rd_req && (reg_sel == REG_RXDATA) && !rx_empty;
  assign clr_req     = wr_req && (reg_sel == REG_CLEAR);

  assign rx_head     = rx_mem[rx_rd_ptr_q];

  // STATUS reflects the state before any access in the current cycle.
  assign status_word = {8'h00,
                        8'(rx_count_q),
                        8'(tx_count_q),
                        3'b000,
                        tx_drop_q,
                        rx_overrun_q,
                        !rx_empty,
                        tx_empty,
                        tx_full};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign send_req.valid = !tx_empty;
  assign send_req.data  = tx_mem[tx_rd_ptr_q];
  assign recv_rsp.ready = 1'b1;
  assign rx_irq         = !rx_empty;
  assign mmio_rdata     = rdata_q;

  // Next-state for pointers, counts, sticky flags and read data.
  always_comb begin
    tx_wr_ptr_d  = tx_wr_ptr_q;
    tx_rd_ptr_d  = tx_rd_ptr_q;
    tx_count_d   = tx_count_q;
    rx_wr_ptr_d  = rx_wr_ptr_q;
    rx_rd_ptr_d  = rx_rd_ptr_q;
    rx_count_d   = rx_count_q;
    rx_overrun_d = rx_overrun_q;
    tx_drop_d    = tx_drop_q;
    rdata_d      = 32'h0;

    if (tx_push) begin
      tx_wr_ptr_d = tx_wr_ptr_q + TX_PTR_ONE;
    end
    if (tx_pop) begin
      tx_rd_ptr_d = tx_rd_ptr_q + TX_PTR_ONE;
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
      2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_push) begin
      rx_wr_ptr_d = rx_wr_ptr_q + RX_PTR_ONE;
    end
    if (rx_pop) begin
      rx_rd_ptr_d = rx_rd_ptr_q + RX_PTR_ONE;
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
      2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
      default: rx_count_d = rx_count_q;
    endcase

    // Clears are applied first so that a loss event in the same cycle is
    // still recorded.
    if (clr_req && mmio_wdata[0]) begin
      rx_overrun_d = 1'b0;
    end
    if (clr_req && mmio_wdata[1]) begin
      tx_drop_d = 1'b0;
    end
    if (recv_rsp.valid && rx_full) begin
      rx_overrun_d = 1'b1;
    end
    if (tx_push_req && tx_full) begin
      tx_drop_d = 1'b1;
    end

    if (rd_req) begin
      case (reg_sel)
        REG_STATUS: rdata_d = status_word;
        REG_RXDATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        default:    rdata_d = 32'h0;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      rdata_q      <= rdata_d;
    end
  end

  // FIFO storage writes; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr_q] <= mmio_wdata[7:0];
    end
    if (rx_push) begin
      rx_mem[rx_wr_ptr_q] <= recv_rsp.data;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: directed bus/stream stimulus, a queue-based model
// checked every cycle, and literal expectations from the register map.
module tb_uart_mmio_fifo;

  localparam int TXD = 16;
  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_en;
  logic        mmio_we;
  logic [3:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        rx_irq;

  rv_if #(.W(8)) send_if ();
  rv_if #(.W(8)) recv_if ();

  uart_mmio_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_en    (mmio_en),
    .mmio_we    (mmio_we),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .send_req   (send_if),
    .recv_rsp   (recv_if),
    .rx_irq     (rx_irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: queues plus sticky flags
  // ---------------------------------------------------------------------------
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_ovr   = 1'b0;
  logic        m_drop  = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          m_txc;
  int          m_rxc;
  logic [31:0] m_rd;

  always @(posedge clk) begin
    m_txc = m_tx.size();
    m_rxc = m_rx.size();
    m_rd  = 32'h0;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_ovr  = 1'b0;
      m_drop = 1'b0;
    end else begin
      if (mmio_en && !mmio_we) begin
        if (mmio_addr[3:2] == 2'd0)
          m_rd = {8'h00, 8'(m_rxc), 8'(m_txc), 3'b000, m_drop, m_ovr,
                  (m_rxc != 0), (m_txc == 0), (m_txc == TXD)};
        else if (mmio_addr[3:2] == 2'd2 && m_rxc != 0)
          m_rd = {24'h0, m_rx.pop_front()};
      end
      if (mmio_en && mmio_we && mmio_addr[3:2] == 2'd3) begin
        if (mmio_wdata[0]) m_ovr = 1'b0;
        if (mmio_wdata[1]) m_drop = 1'b0;
      end
      if (m_txc != 0 && send_if.ready) void'(m_tx.pop_front());
      if (mmio_en && mmio_we && mmio_addr[3:2] == 2'd1) begin
        if (m_txc < TXD) m_tx.push_back(mmio_wdata[7:0]);
        else             m_drop = 1'b1;
      end
      if (recv_if.valid) begin
        if (m_rxc < RXD) m_rx.push_back(recv_if.data);
        else             m_ovr = 1'b1;
      end
    end
    m_rdata = m_rd;
  end

  // Record every byte handed to the transmitter.
  logic [7:0] beats[$];
  always @(posedge clk) begin
    if (!rst && send_if.valid && send_if.ready) beats.push_back(send_if.data);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata", mmio_rdata, m_rdata);
      check("tx_valid", 32'(send_if.valid), 32'(m_tx.size() != 0));
      if (m_tx.size() != 0) check("tx_data", 32'(send_if.data), 32'(m_tx[0]));
      check("rx_irq", 32'(rx_irq), 32'(m_rx.size() != 0));
      check("rx_ready", 32'(recv_if.ready), 32'h1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 ns after the rising edge
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = a; mmio_wdata = d;
    tick();
    mmio_en = 1'b0; mmio_we = 1'b0;
    $display("wr addr=0x%0h data=0x%08h", a, d);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] r);
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = a;
    tick();
    mmio_en = 1'b0;
    r = mmio_rdata;
    $display("rd addr=0x%0h data=0x%08h", a, r);
  endtask

  task automatic rx_beat(input logic [7:0] d);
    recv_if.valid = 1'b1; recv_if.data = d;
    tick();
    recv_if.valid = 1'b0;
    $display("rx beat data=0x%02h", d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] r;
  logic [7:0]  exp_beats [3];

  initial begin
    rst = 1'b1; mmio_en = 1'b0; mmio_we = 1'b0; mmio_addr = 4'h0; mmio_wdata = 32'h0;
    send_if.ready = 1'b0; recv_if.valid = 1'b0; recv_if.data = 8'h00;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // 1. Reset state.
    check("reset_rdata", mmio_rdata, 32'h0);
    check("reset_valid", 32'(send_if.valid), 32'h0);
    check("reset_irq", 32'(rx_irq), 32'h0);
    bus_rd(4'h0, r); check("reset_status", r, 32'h0000_0002);

    // 2. Three bytes held, then released in order.
    bus_wr(4'h4, 32'h41); bus_wr(4'h4, 32'h42); bus_wr(4'h4, 32'h43);
    bus_rd(4'h0, r); check("tx3_status", r, 32'h0000_0300);
    tick();
    check("tx_head_stable", 32'(send_if.data), 32'h41);
    beats.delete();
    send_if.ready = 1'b1;
    ticks(5);
    send_if.ready = 1'b0;
    exp_beats = '{8'h41, 8'h42, 8'h43};
    check("beat_count", 32'(beats.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (beats.size() > i) check("beat_data", 32'(beats[i]), 32'(exp_beats[i]));
    check("tx_drained_valid", 32'(send_if.valid), 32'h0);

    // 3. Overfill TX, then clear tx_drop.
    for (int i = 0; i < 17; i++) bus_wr(4'h4, 32'(8'h60 + i));
    bus_rd(4'h0, r); check("tx_full_status", r, 32'h0000_1011);
    bus_wr(4'hC, 32'h2);
    bus_rd(4'h0, r); check("tx_drop_cleared", r, 32'h0000_1001);

    // 5. Push while full with a same-cycle pop: the push is still dropped.
    send_if.ready = 1'b1;
    bus_wr(4'h4, 32'h99);
    send_if.ready = 1'b0;
    bus_rd(4'h0, r); check("full_push_pop", r, 32'h0000_0F10);
    send_if.ready = 1'b1;
    ticks(16);
    send_if.ready = 1'b0;
    bus_wr(4'hC, 32'h2);
    bus_rd(4'h0, r); check("tx_idle_status", r, 32'h0000_0002);

    // 4. RX fill with overrun, drain, read when empty.
    for (int i = 0; i < 17; i++) rx_beat(8'(8'h10 + i));
    bus_rd(4'h0, r); check("rx_full_status", r, 32'h0010_000E);
    check("rx_irq_high", 32'(rx_irq), 32'h1);
    for (int i = 0; i < 16; i++) begin
      bus_rd(4'h8, r); check("rx_data", r, 32'(8'h10 + i));
    end
    check("rx_irq_low", 32'(rx_irq), 32'h0);
    bus_rd(4'h8, r); check("rx_empty_read", r, 32'h0);
    bus_rd(4'h4, r); check("txdata_read", r, 32'h0);
    bus_wr(4'hC, 32'h1);
    bus_rd(4'h0, r); check("ovr_cleared", r, 32'h0000_0002);

    // 6. Reset mid-operation with 5 TX bytes, 3 RX bytes and tx_drop set.
    for (int i = 0; i < 17; i++) bus_wr(4'h4, 32'(8'hA0 + i));
    send_if.ready = 1'b1;
    ticks(11);
    send_if.ready = 1'b0;
    bus_rd(4'h0, r); check("pre_reset_status", r, 32'h0000_0510);
    rx_beat(8'h31); rx_beat(8'h32); rx_beat(8'h33);
    check("pre_reset_irq", 32'(rx_irq), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_reset_valid", 32'(send_if.valid), 32'h0);
    check("post_reset_irq", 32'(rx_irq), 32'h0);
    bus_rd(4'h0, r); check("post_reset_status", r, 32'h0000_0002);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
